// File: rtl/mic1_pkg.sv
// MIC-1 microsequencer shared definitions: microword field layout,
// sequencer states and control-store geometry.
package mic1_pkg;

    localparam int unsigned ADDR_W   = 9;
    localparam int unsigned WORD_W   = 36;

    // Microword field positions
    localparam int unsigned NA_LSB   = 27;
    localparam int unsigned NA_W     = 9;
    localparam int unsigned JMPC_BIT = 26;
    localparam int unsigned JAMN_BIT = 25;
    localparam int unsigned JAMZ_BIT = 24;
    localparam int unsigned ALU_LSB  = 16;
    localparam int unsigned ALU_W    = 8;
    localparam int unsigned C_LSB    = 7;
    localparam int unsigned C_W      = 9;
    localparam int unsigned WR_BIT   = 6;
    localparam int unsigned RD_BIT   = 5;
    localparam int unsigned FE_BIT   = 4;
    localparam int unsigned B_LSB    = 0;
    localparam int unsigned B_W      = 4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        WAIT  = 2'd2
    } seq_state_t;

    // True when the microword requests any memory operation
    function automatic logic mem_op(input logic [WORD_W-1:0] w);
        return w[WR_BIT] | w[RD_BIT] | w[FE_BIT];
    endfunction

endpackage

// File: rtl/mic1_next_addr.sv
// MIC-1 next-address logic: NEXT_ADDRESS OR'd with MBR (JMPC) in the low
// byte, and with the JAMN/JAMZ conditions in bit 8. Pure OR, no carries.
module mic1_next_addr
    import mic1_pkg::*;
(
    input  logic [NA_W-1:0] i_next_addr,
    input  logic            i_jmpc,
    input  logic            i_jamn,
    input  logic            i_jamz,
    input  logic            i_n,
    input  logic            i_z,
    input  logic [7:0]      i_mbr,
    output logic [NA_W-1:0] o_next
);

    logic [7:0] w_low;
    logic       w_high;

    // Combine address fields with the branch conditions
    always_comb begin
        w_low  = i_next_addr[7:0] | (i_jmpc ? i_mbr : 8'h00);
        w_high = i_next_addr[8] | (i_jamz & i_z) | (i_jamn & i_n);
        o_next = {w_high, w_low};
    end

endmodule

// File: rtl/mic1_microsequencer.sv
// MIC-1 control-store sequencer: MPC/MIR, FETCH/EXEC/WAIT sequencing and
// microword decode towards the datapath and the B-bus decoder.
// Optional feature macro: MIC1_SEQ_STEP_EN (adds single-step input 'step').
module mic1_microsequencer #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned WORD_W = 36
) (
    input  logic              clk,
    input  logic              rst,
`ifdef MIC1_SEQ_STEP_EN
    input  logic              step,
`endif
    input  logic [WORD_W-1:0] cs_data,
    input  logic              n_in,
    input  logic              z_in,
    input  logic [7:0]        mbr_in,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] cs_addr,
    output logic [3:0]        b_sel,
    output logic [8:0]        c_en,
    output logic [7:0]        alu_ctrl,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic              mem_fetch,
    output logic              n_q,
    output logic              z_q
);

    import mic1_pkg::*;

    seq_state_t        r_state;
    logic [ADDR_W-1:0] r_mpc;
    logic [WORD_W-1:0] r_mir;
    logic              r_n;
    logic              r_z;
    logic [ADDR_W-1:0] w_next;
    logic              w_fetch_go;

`ifdef MIC1_SEQ_STEP_EN
    assign w_fetch_go = step;
`else
    assign w_fetch_go = 1'b1;
`endif

    mic1_next_addr u_next_addr (
        .i_next_addr (r_mir[NA_LSB +: NA_W]),
        .i_jmpc      (r_mir[JMPC_BIT]),
        .i_jamn      (r_mir[JAMN_BIT]),
        .i_jamz      (r_mir[JAMZ_BIT]),
        .i_n         (n_in),
        .i_z         (z_in),
        .i_mbr       (mbr_in),
        .o_next      (w_next)
    );

    // Sequencer state, MPC/MIR and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
            r_mpc   <= '0;
            r_mir   <= '0;
            r_n     <= 1'b0;
            r_z     <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_fetch_go) begin
                        r_mir   <= cs_data;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_n     <= n_in;
                    r_z     <= z_in;
                    r_mpc   <= w_next;
                    r_state <= mem_op(r_mir) ? WAIT : FETCH;
                end
                WAIT: begin
                    if (mem_ack) begin
                        r_state <= FETCH;
                    end
                end
                default: r_state <= FETCH;
            endcase
        end
    end

    // Datapath controls are live only while executing a microword
    always_comb begin
        c_en      = '0;
        alu_ctrl  = '0;
        mem_wr    = 1'b0;
        mem_rd    = 1'b0;
        mem_fetch = 1'b0;
        if (r_state == EXEC) begin
            c_en      = r_mir[C_LSB +: C_W];
            alu_ctrl  = r_mir[ALU_LSB +: ALU_W];
            mem_wr    = r_mir[WR_BIT];
            mem_rd    = r_mir[RD_BIT];
            mem_fetch = r_mir[FE_BIT];
        end
    end

    assign cs_addr = r_mpc;
    assign b_sel   = r_mir[B_LSB +: B_W];
    assign n_q     = r_n;
    assign z_q     = r_z;

endmodule
